// File: rtl/fp_add_sub_pipe_if.sv
// fp_add_sub_pipe_if
//   Bundles the operand/result streams of fp_add_sub_pipe.
//   Parameters EXP_W/MAN_W must match the pipeline instance.
//   Ports (slave view, i.e. the adder):
//     dina, dinb  in   operands {sign, exp, frac}
//     op          in   0: A+B, 1: A-B
//     valid_in    in   input word valid
//     ready_in    out  pipeline can accept an input
//     result      out  rounded sum/difference
//     flags       out  {invalid, overflow, underflow, inexact}
//     valid_out   out  result/flags valid
//     ready_out   in   consumer accepts the result
interface fp_add_sub_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic [W-1:0] dina;
  logic [W-1:0] dinb;
  logic         op;
  logic         valid_in;
  logic         ready_in;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         valid_out;
  logic         ready_out;

  modport master (
    output dina, dinb, op, valid_in, ready_out,
    input  ready_in, result, flags, valid_out
  );

  modport slave (
    input  dina, dinb, op, valid_in, ready_out,
    output ready_in, result, flags, valid_out
  );
endinterface

// File: rtl/fp_add_sub_pipe.sv
// fp_add_sub_pipe
//   Three-stage pipelined floating-point adder/subtractor with
//   round-to-nearest-even and flush-to-zero of subnormal inputs.
//   Ports:
//     clk  sole clock, rising edge
//     rst  synchronous active-high reset
//     bus  fp_add_sub_pipe_if.slave (operands, op, result, flags, handshake)
//   Stages: S1 unpack/classify/swap/align, S2 magnitude add/sub + LZC,
//   S3 normalise/round/pack/exceptions (registers drive the outputs).
module fp_add_sub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic              clk,
  input logic              rst,
  fp_add_sub_pipe_if.slave bus
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int AL_W  = MAN_W + 4;
  localparam int SUM_W = AL_W + 1;
  localparam int SH_W  = $clog2(AL_W) + 1;
  localparam int LZ_W  = $clog2(SUM_W + 1);
  localparam int EX_W  = EXP_W + 2;
  localparam int XT_W  = EXP_W + SH_W;

  localparam logic [EXP_W-1:0] EXP_ONES   = '1;
  localparam logic [EX_W-1:0]  EXP_MAX    = {2'b00, EXP_ONES};
  localparam logic [XT_W-1:0]  MAX_SH_EXT = XT_W'(MAN_W + 3);
  localparam logic [SH_W-1:0]  MAX_SH     = SH_W'(MAN_W + 3);
  localparam logic [W-1:0]     QNAN       = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic advance;

  // stage 1 combinational
  logic             sa, sb, a_zero, b_zero, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_ge_b;
  logic [EXP_W-1:0] ea, eb, big_exp, small_exp, exp_diff;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0]   big_mant, small_mant;
  logic [SH_W-1:0]  sh;
  logic [2*AL_W-1:0] shift_wide;
  logic [AL_W-1:0]  small_al;
  logic             big_sign, special;
  logic [W-1:0]     special_res;
  logic [3:0]       special_flags;

  // stage 1 registers
  logic             s1_valid, s1_sign, s1_sub, s1_zero_sign, s1_special;
  logic [EXP_W-1:0] s1_exp;
  logic [AL_W-1:0]  s1_big, s1_small;
  logic [W-1:0]     s1_special_res;
  logic [3:0]       s1_special_flags;

  // stage 2
  logic [SUM_W-1:0] sum;
  logic [LZ_W-1:0]  lz;
  logic             found;
  logic             s2_valid, s2_sign, s2_zero_sign, s2_special;
  logic [EXP_W-1:0] s2_exp;
  logic [SUM_W-1:0] s2_sum;
  logic [LZ_W-1:0]  s2_lz;
  logic [W-1:0]     s2_special_res;
  logic [3:0]       s2_special_flags;

  // stage 3
  logic [SUM_W-1:0] norm;
  logic [EX_W-1:0]  exp_n, exp_r;
  logic [MAN_W:0]   mant;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac;
  logic             guard, rnd, sticky, inexact, round_up, underflow, overflow;
  logic [W-1:0]     nxt_result;
  logic [3:0]       nxt_flags;
  logic             out_valid;
  logic [W-1:0]     out_result;
  logic [3:0]       out_flags;

  assign advance      = !(out_valid && !bus.ready_out);
  assign bus.ready_in = advance;
  assign bus.valid_out = out_valid;
  assign bus.result    = out_result;
  assign bus.flags     = out_flags;

  assign sa = bus.dina[W-1];
  assign ea = bus.dina[W-2 -: EXP_W];
  assign fa = bus.dina[MAN_W-1:0];
  assign sb = bus.dinb[W-1] ^ bus.op;
  assign eb = bus.dinb[W-2 -: EXP_W];
  assign fb = bus.dinb[MAN_W-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_snan = a_nan && !fa[MAN_W-1];
  assign b_snan = b_nan && !fb[MAN_W-1];

  // Subnormals count as zero, so their fraction is ignored in the magnitude compare.
  assign a_ge_b = {ea, a_zero ? {MAN_W{1'b0}} : fa} >= {eb, b_zero ? {MAN_W{1'b0}} : fb};

  // Swap so the larger magnitude is "big", then align the smaller one; any
  // bit pushed below the sticky position is ORed into sticky.
  always_comb begin
    big_sign   = a_ge_b ? sa : sb;
    big_exp    = a_ge_b ? ea : eb;
    small_exp  = a_ge_b ? eb : ea;
    big_mant   = a_ge_b ? (a_zero ? '0 : {1'b1, fa}) : (b_zero ? '0 : {1'b1, fb});
    small_mant = a_ge_b ? (b_zero ? '0 : {1'b1, fb}) : (a_zero ? '0 : {1'b1, fa});
    exp_diff   = big_exp - small_exp;
    sh         = ({{SH_W{1'b0}}, exp_diff} > MAX_SH_EXT) ? MAX_SH : exp_diff[SH_W-1:0];
    shift_wide = {small_mant, 3'b000, {AL_W{1'b0}}} >> sh;
    small_al   = shift_wide[2*AL_W-1:AL_W];
    small_al[0] = small_al[0] | (|shift_wide[AL_W-1:0]);
  end

  // NaN and infinity results are decided up front and bypass the datapath.
  always_comb begin
    special       = 1'b1;
    special_res   = QNAN;
    special_flags = 4'b0000;
    if (a_nan || b_nan) begin
      special_flags = {a_snan || b_snan, 3'b000};
    end else if (a_inf && b_inf && (sa != sb)) begin
      special_flags = 4'b1000;
    end else if (a_inf) begin
      special_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      special_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // Stage 1 register. A zero result can only be negative when both inputs
  // were negative zeros, which is exactly sa & sb.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (advance) begin
      s1_valid         <= bus.valid_in;
      s1_sign          <= big_sign;
      s1_sub           <= (sa != sb);
      s1_zero_sign     <= sa & sb;
      s1_exp           <= big_exp;
      s1_big           <= {big_mant, 3'b000};
      s1_small         <= small_al;
      s1_special       <= special;
      s1_special_res   <= special_res;
      s1_special_flags <= special_flags;
    end
  end

  // Magnitude add/subtract (big >= small so no negative result) and a
  // leading-zero count for normalisation.
  always_comb begin
    sum   = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small}) : ({1'b0, s1_big} + {1'b0, s1_small});
    lz    = '0;
    found = 1'b0;
    for (int i = SUM_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz    = lz + LZ_W'(1);
      end
    end
  end

  // Stage 2 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (advance) begin
      s2_valid         <= s1_valid;
      s2_sign          <= s1_sign;
      s2_zero_sign     <= s1_zero_sign;
      s2_exp           <= s1_exp;
      s2_sum           <= sum;
      s2_lz            <= lz;
      s2_special       <= s1_special;
      s2_special_res   <= s1_special_res;
      s2_special_flags <= s1_special_flags;
    end
  end

  // Normalise so the leading one sits in the carry position, then round
  // to nearest-even on guard/round/sticky and pack with exception checks.
  always_comb begin
    norm      = s2_sum << s2_lz;
    exp_n     = {2'b00, s2_exp} + EX_W'(1) - EX_W'(s2_lz);
    mant      = norm[SUM_W-1:4];
    guard     = norm[3];
    rnd       = norm[2];
    sticky    = |norm[1:0];
    inexact   = guard | rnd | sticky;
    round_up  = guard & (rnd | sticky | mant[0]);
    mant_r    = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};
    exp_r     = exp_n + EX_W'(mant_r[MAN_W+1]);
    frac      = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    underflow = exp_n[EX_W-1] || (exp_n == '0);
    overflow  = !exp_r[EX_W-1] && (exp_r >= EXP_MAX);

    nxt_result = '0;
    nxt_flags  = 4'b0000;
    if (s2_special) begin
      nxt_result = s2_special_res;
      nxt_flags  = s2_special_flags;
    end else if (s2_sum == '0) begin
      nxt_result = {s2_zero_sign, {(W-1){1'b0}}};
    end else if (underflow) begin
      nxt_result = {s2_sign, {(W-1){1'b0}}};
      nxt_flags  = 4'b0011;
    end else if (overflow) begin
      nxt_result = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      nxt_flags  = 4'b0101;
    end else begin
      nxt_result = {s2_sign, exp_r[EXP_W-1:0], frac};
      nxt_flags  = {3'b000, inexact};
    end
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= 4'b0000;
    end else if (advance) begin
      out_valid  <= s2_valid;
      out_result <= nxt_result;
      out_flags  <= nxt_flags;
    end
  end
endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// tb_fp_add_sub_pipe
//   Directed-vector bench for fp_add_sub_pipe (default EXP_W=8, MAN_W=23).
//   Expected values are hand-computed single-precision results.
module tb_fp_add_sub_pipe;
  logic clk = 1'b0;
  logic rst;
  int   num_checks = 0;
  int   num_fails  = 0;
  int   sent;
  int   got;

  logic [31:0] stream_a   [5] = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h3F800000, 32'h40400000};
  logic [31:0] stream_b   [5] = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F000000, 32'h3F800000};
  logic        stream_op  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] stream_exp [5] = '{32'h40400000, 32'h40800000, 32'h40A00000, 32'h3FC00000, 32'h40000000};

  always #5 clk = ~clk;

  fp_add_sub_pipe_if bus ();

  fp_add_sub_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic op_v);
    bus.dina     = a;
    bus.dinb     = b;
    bus.op       = op_v;
    bus.valid_in = 1'b1;
  endtask

  // One isolated operation: result must be absent after 2 edges, present after 3.
  task automatic runSingle(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic op_v, input logic [31:0] exp_res, input logic [3:0] exp_flags);
    applyStimulus(a, b, op_v);
    nextCycle();
    bus.valid_in = 1'b0;
    nextCycle();
    checkOutput({tag, "_early"}, 32'(bus.valid_out), 32'd0);
    nextCycle();
    checkOutput({tag, "_valid"}, 32'(bus.valid_out), 32'd1);
    checkOutput({tag, "_result"}, bus.result, exp_res);
    checkOutput({tag, "_flags"}, 32'(bus.flags), 32'(exp_flags));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.dina      = '0;
    bus.dinb      = '0;
    bus.op        = 1'b0;
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b1;
    nextCycle();
    nextCycle();
    checkOutput("reset_valid", 32'(bus.valid_out), 32'd0);
    checkOutput("reset_result", bus.result, 32'h0);
    checkOutput("reset_flags", 32'(bus.flags), 32'd0);
    rst = 1'b0;
    checkOutput("reset_ready_in", 32'(bus.ready_in), 32'd1);

    $display("[TB] directed single operations");
    runSingle("one_plus_two",  32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    runSingle("tie_even",      32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    runSingle("round_up",      32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001);
    runSingle("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
    runSingle("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    runSingle("cancel",        32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    runSingle("ftz_b",         32'h00800000, 32'h00000001, 1'b1, 32'h00800000, 4'b0000);
    runSingle("negz_negz",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    runSingle("posz_negz",     32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000);
    runSingle("inf_plus_one",  32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000);
    runSingle("ninf_ninf",     32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'b0000);
    runSingle("qnan_in",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
    runSingle("snan_in",       32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    runSingle("neg_result",    32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000);
    runSingle("underflow",     32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'b0011);
    runSingle("sat_sticky",    32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001);
    runSingle("carry_norm",    32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000);
    nextCycle();

    $display("[TB] back-to-back stream with output stall");
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      bus.ready_out = !(c >= 3 && c <= 6);
      if (sent < 5) applyStimulus(stream_a[sent], stream_b[sent], stream_op[sent]);
      else          bus.valid_in = 1'b0;
      #1;
      if (c >= 3 && c <= 6) begin
        checkOutput("stall_ready_in", 32'(bus.ready_in), 32'd0);
        checkOutput("stall_hold", bus.result, stream_exp[0]);
      end
      if (bus.valid_in && bus.ready_in) sent++;
      if (bus.valid_out && bus.ready_out) begin
        checkOutput("stream_order", bus.result, stream_exp[got]);
        got++;
      end
      nextCycle();
    end
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b1;
    checkOutput("stream_count", 32'(got), 32'd5);
    checkOutput("stream_drain", 32'(bus.valid_out), 32'd0);
    nextCycle();

    $display("[TB] reset with operations in flight");
    applyStimulus(32'h3F800000, 32'h3F800000, 1'b0);
    nextCycle();
    applyStimulus(32'h40000000, 32'h3F800000, 1'b0);
    nextCycle();
    applyStimulus(32'h40400000, 32'h3F800000, 1'b0);
    rst = 1'b1;
    nextCycle();
    rst          = 1'b0;
    bus.valid_in = 1'b0;
    checkOutput("inflight_valid", 32'(bus.valid_out), 32'd0);
    checkOutput("inflight_ready_in", 32'(bus.ready_in), 32'd1);
    for (int k = 0; k < 6; k++) begin
      nextCycle();
      checkOutput("inflight_discard", 32'(bus.valid_out), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end
endmodule

// File: doc/fp_add_sub_pipe.md
FP_ADD_SUB_PIPE -- requirements
Module: fp_add_sub_pipe

Interface
REQ-001 Parameter EXP_W, default 8: exponent field width.
REQ-002 Parameter MAN_W, default 23: stored fraction width; word width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 dina  input  W  operand A, IEEE-754-style {sign, exp, frac}.
REQ-006 dinb  input  W  operand B.
REQ-007 op  input  1  operation: 0 gives A+B, 1 gives A-B (B sign inverted).
REQ-008 valid_in  input  1  input word valid.
REQ-009 ready_in  output  1  block can accept; a transfer occurs when valid_in && ready_in.
REQ-010 result  output  W  rounded sum or difference.
REQ-011 flags  output  4  {invalid, overflow, underflow, inexact} for result.
REQ-012 valid_out  output  1  result/flags valid.
REQ-013 ready_out  input  1  consumer accepts; output transfer occurs when valid_out && ready_out.

Function
REQ-014 Pipeline: 3 register stages. S1 = unpack, classify, swap so |A|>=|B|, align with guard/round/sticky. S2 = add/subtract magnitudes, leading-zero count. S3 = normalise, round, pack, exceptions.
REQ-015 Latency: an accepted input appears on result exactly 3 cycles later when there is no stall.
REQ-016 Stall: stall = valid_out && !ready_out; while stalled all stages hold; ready_in = !stall.
REQ-017 Bubbles: when not stalled, each stage advances even if the next stage is empty; throughput is 1 per cycle.
REQ-018 result and flags hold stable while valid_out=1 and ready_out=0.
REQ-019 Subnormal inputs (exp=0) are treated as signed zero (flush-to-zero).
REQ-020 Alignment shift saturates at MAN_W+3; every bit shifted out ORs into sticky.
REQ-021 Rounding: round-to-nearest-even on guard/round/sticky; a mantissa carry-out after rounding increments the exponent.
REQ-022 inexact = 1 when any of guard/round/sticky is nonzero after normalisation.
REQ-023 Overflow: biased exponent >= 2^EXP_W-1 after rounding gives signed infinity, overflow=1, inexact=1.
REQ-024 Underflow: biased exponent <= 0 after normalisation gives signed zero, underflow=1, inexact=1.
REQ-025 Exact cancellation gives +0; (-0)+(-0) gives -0; (+0)+(-0) gives +0.
REQ-026 NaN handling: any NaN input, or inf minus inf of the same magnitude direction, gives canonical qNaN {0, all-ones exp, MSB frac 1, rest 0}; invalid=1 only for the inf-minus-inf case or a signalling-NaN input.
REQ-027 Infinity rules: inf op finite gives that inf; inf+inf of the same effective sign gives that inf; no flags are raised.
REQ-028 Sign: the effective sign is the sign of the larger-magnitude operand; for equal exponents the fraction comparison decides.
REQ-029 Parameter rules: all internal widths derive from EXP_W and MAN_W only; no fixed 49-bit or 6-bit literals.

Reset
REQ-030 While rst=1 on a clock edge, all stage valid bits, valid_out, result and flags clear to 0.
REQ-031 In-flight data is discarded on reset; ready_in=1 in the first cycle after rst deasserts.
REQ-032 Assertion of rst takes priority over stall and over a simultaneous input transfer.

Verification (default parameters, ready_out=1 unless stated)
REQ-033 dina=0x3F800000, dinb=0x40000000, op=0 accepted at cycle T -> result=0x40400000, flags=0, valid_out=1 at T+3.
REQ-034 dina=0x3F800000, dinb=0x33800000, op=0 (tie) -> 0x3F800000, inexact=1; dinb=0x33C00000 -> 0x3F800001, inexact=1.
REQ-035 dina=0x7F800000, dinb=0x7F800000, op=1 -> 0x7FC00000, invalid=1; dina=0x7F7FFFFF, dinb=0x7F7FFFFF, op=0 -> 0x7F800000, overflow=1, inexact=1.
REQ-036 dina=0x3F800000, dinb=0x3F800000, op=1 -> 0x00000000; dina=0x00800000, dinb=0x00000001, op=1 -> 0x00800000 (subnormal B flushed to zero).
REQ-037 Back-to-back stream of 5 inputs with ready_out held 0 for cycles T+3..T+6 -> ready_in=0 during the stall, no loss or duplication, results emerge in order.
REQ-038 rst pulsed while 3 operations are in flight -> valid_out=0 the next cycle, and none of the pre-reset results ever appear.
